// File: rtl/integral_feed_ctrl.sv
// Frame sequencer for the RFFT power-integration block: reads the decode row
// buffer, feeds intergral in head/pair interleave, then checks the returned beat count.
module integral_feed_ctrl #(
   parameter int ROWS   = 2048,
   parameter int IDX_W  = $clog2(ROWS),
   parameter int OUT_TO = 4096
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   output logic             rd_en_a,
   output logic [IDX_W-1:0] rd_addr_a,
   output logic             rd_en_b,
   output logic [IDX_W-1:0] rd_addr_b,
   output logic             valid,
   output logic [IDX_W-1:0] index_col_1,
   output logic [IDX_W-1:0] index_col_2,
   input  logic             ready,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [IDX_W:0]   beat_cnt
);

   localparam int TO_W = $clog2(OUT_TO + 1);
   localparam logic [IDX_W:0]   EXP       = (IDX_W+1)'(ROWS / 2 + 1);
   localparam logic [IDX_W-1:0] LAST_A    = IDX_W'(ROWS - 2);
   localparam logic [IDX_W-1:0] COL2_INIT = IDX_W'(3);
   localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(OUT_TO - 1);

   typedef enum logic [2:0] {
      IDLE,
      HEAD0,
      HEAD1,
      STREAM,
      DRAIN
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic [IDX_W-1:0] row_ptr_q;
   logic [TO_W-1:0]  to_cnt_q;
   logic             ready_q;
   logic             fall;
   logic             timeout;
   logic             accept;
   logic             set_err;

   assign busy    = (state_q != IDLE);
   assign fall    = ready_q && !ready;
   assign timeout = (state_q == DRAIN) && !ready && (to_cnt_q == TO_LAST);
   assign accept  = (state_q == IDLE) && start && !abort;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // A ready drop while still streaming means intergral underran the frame,
   // so it is treated as a failed frame rather than waited out.
   always_comb begin
      state_d   = state_q;
      rd_en_a   = 1'b0;
      rd_addr_a = '0;
      rd_en_b   = 1'b0;
      rd_addr_b = '0;
      done      = 1'b0;
      set_err   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = HEAD0;
            end
         end
         HEAD0: begin
            rd_en_a = 1'b1;
            state_d = HEAD1;
         end
         HEAD1: begin
            rd_en_a   = 1'b1;
            rd_addr_a = IDX_W'(1);
            state_d   = STREAM;
         end
         STREAM: begin
            rd_en_a   = 1'b1;
            rd_en_b   = 1'b1;
            rd_addr_a = row_ptr_q;
            rd_addr_b = row_ptr_q + IDX_W'(1);
            if (fall) begin
               set_err = 1'b1;
               state_d = IDLE;
            end else if (row_ptr_q == LAST_A) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (fall) begin
               if (beat_cnt == EXP) begin
                  done = 1'b1;
               end else begin
                  set_err = 1'b1;
               end
               state_d = IDLE;
            end else if (timeout) begin
               set_err = 1'b1;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      if (state_q != IDLE && ready && beat_cnt >= EXP) begin
         set_err = 1'b1;
      end
      if (abort) begin
         state_d = IDLE;
         done    = 1'b0;
         set_err = 1'b0;
      end
   end

   // Row pointer walks the even col1 rows; it is pre-loaded so STREAM starts at row 2.
   always_ff @(posedge clk) begin
      if (rst) begin
         row_ptr_q <= IDX_W'(2);
         ready_q   <= 1'b0;
         to_cnt_q  <= '0;
      end else begin
         row_ptr_q <= (state_q == STREAM) ? row_ptr_q + IDX_W'(2) : IDX_W'(2);
         ready_q   <= ready;
         to_cnt_q  <= (state_q == DRAIN && !ready) ? to_cnt_q + TO_W'(1) : '0;
      end
   end

   // Slot outputs line up with the 1-cycle buffer latency; the last slot of a
   // frame that is being cut short is dropped so downstream never sees it.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid       <= 1'b0;
         index_col_1 <= '0;
         index_col_2 <= COL2_INIT;
      end else begin
         valid <= rd_en_a && (state_d != IDLE);
         if (rd_en_a) begin
            index_col_1 <= rd_addr_a;
         end
         if (rd_en_b) begin
            index_col_2 <= rd_addr_b;
         end else if (accept) begin
            index_col_2 <= COL2_INIT;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         err      <= 1'b0;
         beat_cnt <= '0;
      end else if (accept) begin
         err      <= 1'b0;
         beat_cnt <= '0;
      end else begin
         if (set_err) begin
            err <= 1'b1;
         end
         if (state_q != IDLE && ready && beat_cnt != '1) begin
            beat_cnt <= beat_cnt + (IDX_W+1)'(1);
         end
      end
   end

endmodule
